// File: rtl/hdmi_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port memory between video read bursts
// and single-word host writes, alternating grants when both are pending.
module hdmi_fb_arbiter #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FRAME_WORDS = 409920,
    parameter int unsigned BURST_LEN   = 16
) (
    input  logic              clock_pixel,
    input  logic              reset,
    input  logic              vid_req,
    input  logic              vid_frame_start,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned       CntW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CntW-1:0]   LastBeat = CntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StVid,
        StWr
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] vid_addr_q;
    logic [CntW-1:0]   beat_q;
    logic              last_grant_vid_q;
    logic              fs_pend_q;

    logic              grant_vid;
    logic              grant_wr;
    logic [ADDR_W-1:0] burst_base;
    logic [ADDR_W-1:0] burst_next;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? '0 : a + 1'b1;
    endfunction

    // Round-robin between the two requesters, only decided from IDLE.
    always_comb begin
        grant_vid = 1'b0;
        grant_wr  = 1'b0;
        if (state_q == StIdle) begin
            if (vid_req && wr_req) begin
                grant_wr  = last_grant_vid_q;
                grant_vid = !last_grant_vid_q;
            end else begin
                grant_vid = vid_req;
                grant_wr  = wr_req;
            end
        end
    end

    // A frame start coincident with a video grant restarts that burst at 0.
    assign burst_base = vid_frame_start ? '0 : vid_addr_q;
    assign burst_next = addr_inc(burst_base);

    always_ff @(posedge clock_pixel or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            vid_addr_q       <= '0;
            beat_q           <= '0;
            last_grant_vid_q <= 1'b0;
            fs_pend_q        <= 1'b0;
            mem_en           <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            vid_ack          <= 1'b0;
            wr_ack           <= 1'b0;
            vid_rvalid       <= 1'b0;
        end else begin
            vid_ack    <= 1'b0;
            wr_ack     <= 1'b0;
            vid_rvalid <= mem_en & ~mem_we;
            case (state_q)
                StIdle: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (grant_vid) begin
                        state_q          <= StVid;
                        vid_ack          <= 1'b1;
                        last_grant_vid_q <= 1'b1;
                        mem_en           <= 1'b1;
                        mem_addr         <= burst_base;
                        vid_addr_q       <= burst_next;
                        beat_q           <= '0;
                    end else if (grant_wr) begin
                        state_q          <= StWr;
                        wr_ack           <= 1'b1;
                        last_grant_vid_q <= 1'b0;
                        mem_en           <= 1'b1;
                        mem_we           <= 1'b1;
                        mem_addr         <= wr_addr;
                        mem_wdata        <= wr_data;
                        if (vid_frame_start) begin
                            vid_addr_q <= '0;
                        end
                    end else if (vid_frame_start) begin
                        vid_addr_q <= '0;
                    end
                end
                StVid: begin
                    if (beat_q == LastBeat) begin
                        state_q   <= StIdle;
                        mem_en    <= 1'b0;
                        fs_pend_q <= 1'b0;
                        if (fs_pend_q || vid_frame_start) begin
                            vid_addr_q <= '0;
                        end
                    end else begin
                        beat_q     <= beat_q + 1'b1;
                        mem_addr   <= vid_addr_q;
                        vid_addr_q <= addr_inc(vid_addr_q);
                        // Defer the restart so the running burst stays contiguous.
                        if (vid_frame_start) begin
                            fs_pend_q <= 1'b1;
                        end
                    end
                end
                StWr: begin
                    state_q <= StIdle;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    if (vid_frame_start) begin
                        vid_addr_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign vid_rdata = mem_rdata;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_hdmi_fb_arbiter.sv
// Bench for hdmi_fb_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of grants, burst addresses and memory contents.
module tb_hdmi_fb_arbiter;

    localparam int BURST = 16;
    localparam int FRAME = 52;

    logic        clock_pixel = 1'b0;
    logic        reset = 1'b0;
    logic        vid_req = 1'b0;
    logic        vid_frame_start = 1'b0;
    logic        vid_ack;
    logic [23:0] vid_rdata;
    logic        vid_rvalid;
    logic        wr_req = 1'b0;
    logic [7:0]  wr_addr = 8'd0;
    logic [23:0] wr_data = 24'd0;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        busy;

    hdmi_fb_arbiter #(
        .DATA_W     (24),
        .ADDR_W     (8),
        .FRAME_WORDS(FRAME),
        .BURST_LEN  (BURST)
    ) dut (
        .clock_pixel    (clock_pixel),
        .reset          (reset),
        .vid_req        (vid_req),
        .vid_frame_start(vid_frame_start),
        .vid_ack        (vid_ack),
        .vid_rdata      (vid_rdata),
        .vid_rvalid     (vid_rvalid),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ack         (wr_ack),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    always #5 clock_pixel = ~clock_pixel;

    function automatic logic [23:0] init_word(input logic [7:0] a);
        return {a ^ 8'h3c, ~a, a + 8'd17};
    endfunction

    // Synchronous single-port memory: read data one cycle after the strobe.
    logic [23:0] tb_mem [256];
    logic        mem_ready = 1'b0;
    always @(posedge clock_pixel) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(8'(i));
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    int unsigned vectors;
    int unsigned miscompares;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [23:0] ref_mem [256];
    logic [7:0]  addr_q [$];
    logic [7:0]  ptr;
    logic        fs_pend;
    logic        last_vid;
    logic        prev_busy;
    logic        prev_rd;
    logic [23:0] exp_rdata;
    int          wr_wait;
    int          acks_seen;

    task automatic model_reset();
        addr_q.delete();
        ptr       = 8'd0;
        fs_pend   = 1'b0;
        last_vid  = 1'b0;
        prev_busy = 1'b0;
        prev_rd   = 1'b0;
        wr_wait   = 0;
    endtask

    // Called just after each falling edge; input pins still hold what the last rising edge saw.
    task automatic monitor();
        logic       rd;
        logic       exp_v;
        logic       exp_w;
        logic       exp_rd;
        logic [7:0] a;
        logic [7:0] start;
        rd    = mem_en && !mem_we;
        exp_v = 1'b0;
        exp_w = 1'b0;
        if (!prev_busy) begin
            if (vid_req && wr_req) begin
                exp_w = last_vid;
                exp_v = !last_vid;
            end else begin
                exp_v = vid_req;
                exp_w = wr_req;
            end
        end
        check_eq("vid_ack", 32'(vid_ack), 32'(exp_v));
        check_eq("wr_ack", 32'(wr_ack), 32'(exp_w));
        if (vid_ack) acks_seen++;
        if (vid_frame_start) fs_pend = 1'b1;
        if (exp_v) begin
            start   = fs_pend ? 8'd0 : ptr;
            fs_pend = 1'b0;
            for (int i = 0; i < BURST; i++) addr_q.push_back(8'((int'(start) + i) % FRAME));
            ptr      = 8'((int'(start) + BURST) % FRAME);
            last_vid = 1'b1;
        end
        if (exp_w) last_vid = 1'b0;
        check_eq("vid_rvalid", 32'(vid_rvalid), 32'(prev_rd));
        if (prev_rd && vid_rvalid) check_eq("vid_rdata", 32'(vid_rdata), 32'(exp_rdata));
        exp_rd = (addr_q.size() > 0);
        check_eq("rd_strobe", 32'(rd), 32'(exp_rd));
        if (exp_rd) begin
            a = addr_q.pop_front();
            check_eq("rd_addr", 32'(mem_addr), 32'(a));
            exp_rdata = ref_mem[a];
        end
        check_eq("wr_strobe", 32'(mem_en && mem_we), 32'(exp_w));
        if (exp_w) begin
            check_eq("wr_addr", 32'(mem_addr), 32'(wr_addr));
            check_eq("wr_data", 32'(mem_wdata), 32'(wr_data));
            ref_mem[wr_addr] = wr_data;
        end
        check_eq("busy", 32'(busy), 32'(exp_rd || exp_w));
        check_eq("ack_excl", 32'(vid_ack && wr_ack), 32'd0);
        if (wr_req && !wr_ack) wr_wait++;
        else                   wr_wait = 0;
        check_eq("wr_starve", 32'(wr_wait > BURST + 2), 32'd0);
        prev_busy = exp_rd || exp_w;
        prev_rd   = exp_rd;
    endtask

    task automatic tick();
        @(posedge clock_pixel);
        @(negedge clock_pixel);
        monitor();
    endtask

    task automatic apply_reset();
        reset           = 1'b1;
        vid_req         = 1'b0;
        wr_req          = 1'b0;
        vid_frame_start = 1'b0;
        repeat (2) @(negedge clock_pixel);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_vid_ack", 32'(vid_ack), 32'd0);
        check_eq("rst_wr_ack", 32'(wr_ack), 32'd0);
        check_eq("rst_rvalid", 32'(vid_rvalid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        acks_seen = 0;
        model_reset();
    endtask

    // One video burst; optionally pulse frame start after word index fs_at is seen.
    task automatic burst(input int fs_at, output logic [7:0] first, output logic [7:0] last);
        logic got;
        got     = 1'b0;
        vid_req = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = vid_ack;
        end
        check_eq("burst_grant", 32'(got), 32'd1);
        vid_req = 1'b0;
        first   = mem_addr;
        last    = mem_addr;
        for (int i = 0; i < BURST; i++) begin
            if (i > 0) tick();
            last            = mem_addr;
            vid_frame_start = (i == fs_at);
        end
        tick();
        vid_frame_start = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0]  f;
        logic [7:0]  l;
        logic [3:0]  order;
        int          n;
        logic        got;
        logic [7:0]  cur_a;
        logic [23:0] cur_d;

        vectors     = 0;
        miscompares = 0;
        acks_seen   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

        // Single burst from reset
        apply_reset();
        vid_req = 1'b1;
        tick();
        check_eq("d1_ack", 32'(vid_ack), 32'd1);
        vid_req = 1'b0;
        for (int i = 0; i < BURST; i++) begin
            if (i > 0) tick();
            check_eq("d1_addr", 32'(mem_addr), 32'(i));
            check_eq("d1_busy", 32'(busy), 32'd1);
        end
        tick();
        check_eq("d1_idle", 32'(busy), 32'd0);
        check_eq("d1_last_rvalid", 32'(vid_rvalid), 32'd1);
        tick();
        check_eq("d1_rvalid_end", 32'(vid_rvalid), 32'd0);

        // Both requesters held: grants alternate
        apply_reset();
        cur_a   = 8'h21;
        cur_d   = 24'ha5c3e1;
        vid_req = 1'b1;
        wr_req  = 1'b1;
        wr_addr = cur_a;
        wr_data = cur_d;
        order   = 4'd0;
        n       = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            tick();
            if (vid_ack) begin
                order = {order[2:0], 1'b1};
                n++;
            end
            if (wr_ack) begin
                order = {order[2:0], 1'b0};
                n++;
                check_eq("d2_wr_addr", 32'(mem_addr), 32'(cur_a));
                check_eq("d2_wr_data", 32'(mem_wdata), 32'(cur_d));
                cur_a   = cur_a + 8'd3;
                cur_d   = cur_d + 24'h010203;
                wr_addr = cur_a;
                wr_data = cur_d;
            end
        end
        check_eq("d2_grants", 32'(n), 32'd4);
        check_eq("d2_order", 32'(order), 32'b1010);
        vid_req = 1'b0;
        wr_req  = 1'b0;
        repeat (BURST + 4) tick();

        // Address wrap at the frame end, mid-burst
        apply_reset();
        burst(-1, f, l);
        check_eq("d3_b1_first", 32'(f), 32'd0);
        burst(-1, f, l);
        check_eq("d3_b2_first", 32'(f), 32'd16);
        burst(-1, f, l);
        burst(-1, f, l);
        check_eq("d3_b4_first", 32'(f), 32'd48);
        check_eq("d3_b4_last", 32'(l), 32'd11);

        // Frame start during a burst takes effect on the next burst
        apply_reset();
        burst(-1, f, l);
        burst(-1, f, l);
        burst(4, f, l);
        check_eq("d4_b3_first", 32'(f), 32'd32);
        check_eq("d4_b3_last", 32'(l), 32'd47);
        burst(-1, f, l);
        check_eq("d4_b4_first", 32'(f), 32'd0);

        // Asynchronous reset in the middle of a burst
        apply_reset();
        vid_req = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            got = vid_ack;
        end
        check_eq("d5_grant", 32'(got), 32'd1);
        vid_req = 1'b0;
        repeat (7) tick();
        check_eq("d5_word8", 32'(mem_addr), 32'd7);
        reset = 1'b1;
        #1;
        check_eq("d5_abort_en", 32'(mem_en), 32'd0);
        check_eq("d5_abort_busy", 32'(busy), 32'd0);
        check_eq("d5_abort_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clock_pixel);
        reset = 1'b0;
        model_reset();
        burst(-1, f, l);
        check_eq("d5_restart_first", 32'(f), 32'd0);
        check_eq("d5_restart_last", 32'(l), 32'd15);
        check_eq("d5_acks", 32'(acks_seen), 32'd2);

        // Randomized traffic with withdrawals and frame starts
        apply_reset();
        for (int c = 0; c < 20000; c++) begin
            tick();
            if (vid_ack)       vid_req = ($urandom_range(0, 3) == 0);
            else if (!vid_req) vid_req = ($urandom_range(0, 5) == 0);
            else if ($urandom_range(0, 40) == 0) vid_req = 1'b0;
            if (wr_ack || !wr_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr_req  = 1'b1;
                    wr_addr = 8'($urandom_range(0, 63));
                    wr_data = 24'($urandom);
                end else begin
                    wr_req = 1'b0;
                end
            end else if ($urandom_range(0, 30) == 0) begin
                wr_req = 1'b0;
            end
            vid_frame_start = ($urandom_range(0, 79) == 0);
        end
        vid_req         = 1'b0;
        wr_req          = 1'b0;
        vid_frame_start = 1'b0;
        repeat (BURST + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdmi_fb_arbiter.md
HDMI_FB_ARBITER -- requirements
Module: hdmi_fb_arbiter

Interface
REQ-001 Parameter DATA_W, default 24: pixel word width ({R,G,B} 8 bits each).
REQ-002 Parameter ADDR_W, default 19: frame memory word address width.
REQ-003 Parameter FRAME_WORDS, default 409920 (854x480): video address wrap point.
REQ-004 Parameter BURST_LEN, default 16: words per video read burst; legal range 2..256.
REQ-005 Clocking and reset SHALL be: one clock, clock_pixel; reset is asynchronous and active-high, named reset.
REQ-006 clock_pixel  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 vid_req  in  1  video line buffer needs one burst; level, held until vid_ack.
REQ-009 vid_frame_start  in  1  one-cycle pulse; restart video read address at 0.
REQ-010 vid_ack  out  1  one-cycle pulse: burst accepted.
REQ-011 vid_rdata  out  DATA_W  video read data.
REQ-012 vid_rvalid  out  1  vid_rdata valid this cycle.
REQ-013 wr_req  in  1  host write request; level, with wr_addr/wr_data held stable until wr_ack.
REQ-014 wr_addr  in  ADDR_W  host write address.
REQ-015 wr_data  in  DATA_W  host write data.
REQ-016 wr_ack  out  1  one-cycle pulse: write performed.
REQ-017 mem_en  out  1  memory access strobe.
REQ-018 mem_we  out  1  1 = write, 0 = read (valid with mem_en).
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid exactly 1 cycle after a read strobe.
REQ-022 busy  out  1  FSM not in IDLE.

Function
REQ-023 FSM states SHALL be IDLE, VID, WR. All memory outputs are registered.
REQ-024 IDLE, neither request: stays IDLE, mem_en=0.
REQ-025 IDLE, vid_req only: vid_ack pulses, FSM goes to VID next cycle.
REQ-026 IDLE, wr_req only: FSM goes to WR.
REQ-027 IDLE, both requests: WR if last_grant_vid=1, else VID. last_grant_vid is set on each video grant and cleared on each write grant. A pending write therefore never waits more than one burst.
REQ-028 VID: mem_en=1, mem_we=0 for exactly BURST_LEN consecutive cycles, addresses vid_addr, vid_addr+1, ...
REQ-029 vid_addr SHALL wrap from FRAME_WORDS-1 to 0, including mid-burst.
REQ-030 After the last word of a burst, FSM returns to IDLE. Minimum one IDLE cycle between grants.
REQ-031 WR: single cycle with mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
REQ-032 wr_ack pulses in the same cycle as the WR strobe; FSM then returns to IDLE.
REQ-033 vid_rvalid SHALL equal (mem_en & ~mem_we) delayed one cycle; vid_rdata = mem_rdata.
REQ-034 Exactly BURST_LEN vid_rvalid pulses per vid_ack; latency from first read strobe to first rvalid is 1 cycle.
REQ-035 vid_frame_start in IDLE: vid_addr=0 next cycle.
REQ-036 vid_frame_start during VID: the current burst completes unchanged; vid_addr is set to 0 when the FSM returns to IDLE (pending flag).
REQ-037 vid_frame_start coincident with a video grant: the granted burst starts at address 0.
REQ-038 wr_req deasserted before ack: request withdrawn, no write performed. vid_req deasserted before ack: no burst performed.

Reset
REQ-039 Reset SHALL force: FSM=IDLE, vid_addr=0, last_grant_vid=0, frame-start pending=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, vid_ack=0, wr_ack=0, vid_rvalid=0, busy=0.
REQ-040 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously). No rvalid follows except from a read issued before reset. After release the FSM resumes from IDLE at address 0.

Verification
REQ-041 Reset, then vid_req held -> vid_ack at cycle 1; addresses 0..15 on 16 consecutive read strobes; 16 rvalid pulses lagging by one cycle; busy high for 16 cycles.
REQ-042 vid_req and wr_req held together from reset -> grant order VID, WR, VID, WR; wr_ack pulse carries the correct wr_addr/wr_data on mem_*.
REQ-043 FRAME_WORDS=20, BURST_LEN=16, two bursts -> second burst addresses 16,17,18,19,0..11.
REQ-044 vid_frame_start pulsed at the 5th word of a burst starting at 32 -> burst continues 36..47; next burst starts at 0.
REQ-045 Reset asserted at the 8th word of a burst -> mem_en=0 immediately; next burst after release starts at 0; ack count matches burst count.
REQ-046 Random vid_req/wr_req/withdrawals for 100k cycles, memory model and scoreboard -> read data matches the model; no write starved longer than BURST_LEN+2 cycles; no write and read strobe in the same cycle.
